// File: rtl/riscv_icu_seq.sv
// Execute-stage sequencer and EX/MEM result register for the compute unit.
// Holds the pipeline for mul/div, drains flushed ops, aborts hung ones.
module riscv_icu_seq #(
    parameter int TIMEOUT = 96
) (
    input  logic        i_riscv_icuseq_clk,
    input  logic        i_riscv_icuseq_rst,
    input  logic        i_riscv_icuseq_instvalid,
    input  logic [1:0]  i_riscv_icuseq_funcsel,
    input  logic        i_riscv_icuseq_flush,
    input  logic        i_riscv_icuseq_icuvalid,
    input  logic [63:0] i_riscv_icuseq_icuresult,
    input  logic [4:0]  i_riscv_icuseq_rdaddr,
    input  logic        i_riscv_icuseq_regwrite,
    output logic        o_riscv_icuseq_stall,
    output logic [63:0] o_riscv_icuseq_result,
    output logic [4:0]  o_riscv_icuseq_rdaddr,
    output logic        o_riscv_icuseq_regwrite,
    output logic        o_riscv_icuseq_resvalid,
    output logic        o_riscv_icuseq_timeout,
    output logic [6:0]  o_riscv_icuseq_busycnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    localparam logic [6:0] LAST_CNT = 7'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic [6:0] busycnt_nx;
    logic       md;
    logic       timed_out;
    logic       abort;
    logic       bubble;
    logic       stall;

    assign md        = i_riscv_icuseq_instvalid & ~i_riscv_icuseq_funcsel[1];
    assign timed_out = (o_riscv_icuseq_busycnt == LAST_CNT) &
                       ~i_riscv_icuseq_icuvalid;

    assign o_riscv_icuseq_stall = stall;

    // Next state, stall and busy counter; the counter restarts on each entry.
    always_comb begin
        state_nx   = state;
        stall      = 1'b0;
        abort      = 1'b0;
        busycnt_nx = 7'd0;
        case (state)
            IDLE: begin
                if (md & ~i_riscv_icuseq_flush & ~i_riscv_icuseq_icuvalid) begin
                    state_nx = WAIT;
                    stall    = 1'b1;
                end
            end
            WAIT: begin
                if (i_riscv_icuseq_icuvalid) begin
                    state_nx = IDLE;
                end else if (timed_out) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end else if (i_riscv_icuseq_flush) begin
                    state_nx = DRAIN;
                end else begin
                    stall      = 1'b1;
                    busycnt_nx = o_riscv_icuseq_busycnt + 7'd1;
                end
            end
            DRAIN: begin
                if (i_riscv_icuseq_icuvalid) begin
                    state_nx = IDLE;
                end else if (timed_out) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end else begin
                    stall      = 1'b1;
                    busycnt_nx = o_riscv_icuseq_busycnt + 7'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // A drained result belongs to a killed instruction, so DRAIN never writes.
    assign bubble = stall | i_riscv_icuseq_flush | abort | (state == DRAIN);

    // State, busy counter and sticky timeout flag.
    always_ff @(posedge i_riscv_icuseq_clk) begin
        if (!i_riscv_icuseq_rst) begin
            state                  <= IDLE;
            o_riscv_icuseq_busycnt <= 7'd0;
            o_riscv_icuseq_timeout <= 1'b0;
        end else begin
            state                  <= state_nx;
            o_riscv_icuseq_busycnt <= busycnt_nx;
            o_riscv_icuseq_timeout <= o_riscv_icuseq_timeout | abort;
        end
    end

    // EX/MEM register; bubbles keep result/rd and only clear the valids.
    always_ff @(posedge i_riscv_icuseq_clk) begin
        if (!i_riscv_icuseq_rst) begin
            o_riscv_icuseq_result   <= 64'd0;
            o_riscv_icuseq_rdaddr   <= 5'd0;
            o_riscv_icuseq_regwrite <= 1'b0;
            o_riscv_icuseq_resvalid <= 1'b0;
        end else if (bubble) begin
            o_riscv_icuseq_regwrite <= 1'b0;
            o_riscv_icuseq_resvalid <= 1'b0;
        end else begin
            o_riscv_icuseq_result   <= i_riscv_icuseq_icuresult;
            o_riscv_icuseq_rdaddr   <= i_riscv_icuseq_rdaddr;
            o_riscv_icuseq_regwrite <= i_riscv_icuseq_regwrite &
                                       i_riscv_icuseq_instvalid;
            o_riscv_icuseq_resvalid <= i_riscv_icuseq_instvalid;
        end
    end

endmodule

// File: tb/tb_riscv_icu_seq.sv
// Self-checking bench for riscv_icu_seq: per-scenario tasks plus a
// scoreboard that matches every live EX/MEM result in order.
module tb_riscv_icu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic [1:0]  fs;
    logic        fl;
    logic        icv;
    logic [63:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        stall;
    logic [63:0] o_res;
    logic [4:0]  o_rd;
    logic        o_rw;
    logic        o_rv;
    logic        o_to;
    logic [6:0]  bcnt;

    int nt = 0;
    int nf = 0;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    riscv_icu_seq #(.TIMEOUT(8)) dut (
        .i_riscv_icuseq_clk       (clk),
        .i_riscv_icuseq_rst       (rst),
        .i_riscv_icuseq_instvalid (iv),
        .i_riscv_icuseq_funcsel   (fs),
        .i_riscv_icuseq_flush     (fl),
        .i_riscv_icuseq_icuvalid  (icv),
        .i_riscv_icuseq_icuresult (res),
        .i_riscv_icuseq_rdaddr    (rd),
        .i_riscv_icuseq_regwrite  (rw),
        .o_riscv_icuseq_stall     (stall),
        .o_riscv_icuseq_result    (o_res),
        .o_riscv_icuseq_rdaddr    (o_rd),
        .o_riscv_icuseq_regwrite  (o_rw),
        .o_riscv_icuseq_resvalid  (o_rv),
        .o_riscv_icuseq_timeout   (o_to),
        .o_riscv_icuseq_busycnt   (bcnt)
    );

    // Scoreboard: every live output must match the oldest expected entry.
    always @(negedge clk) begin
        if (o_rv === 1'b1) begin
            nt++;
            if (sb.size() == 0) begin
                nf++;
                $display("FAIL sb_unexpected: got res=%h rd=%0d rw=%b, none expected",
                         o_res, o_rd, o_rw);
            end else begin
                mon_e = sb.pop_front();
                if ({o_res, o_rd, o_rw} !== {mon_e.res, mon_e.rd, mon_e.rw}) begin
                    nf++;
                    $display("FAIL sb_result: got res=%h rd=%0d rw=%b, want res=%h rd=%0d rw=%b",
                             o_res, o_rd, o_rw, mon_e.res, mon_e.rd, mon_e.rw);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drv(input logic v, input logic [1:0] f, input logic k,
                       input logic c, input logic [63:0] r,
                       input logic [4:0] d, input logic w);
        iv  = v;
        fs  = f;
        fl  = k;
        icv = c;
        res = r;
        rd  = d;
        rw  = w;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drv(1'b0, 2'b00, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0);
        repeat (2) tick;
        rst = 1'b1;
        #1;
        nt++;
        if (stall !== 1'b0) begin
            nf++; $display("FAIL reset_stall: got %b want 0", stall);
        end
        nt++;
        if ({o_res, o_rd, o_rw, o_rv} !== 71'd0) begin
            nf++;
            $display("FAIL reset_outputs: got res=%h rd=%0d rw=%b rv=%b want all 0",
                     o_res, o_rd, o_rw, o_rv);
        end
        nt++;
        if (o_to !== 1'b0) begin
            nf++; $display("FAIL reset_timeout: got %b want 0", o_to);
        end
        nt++;
        if (bcnt !== 7'd0) begin
            nf++; $display("FAIL reset_busycnt: got %0d want 0", bcnt);
        end
    endtask

    task automatic test_alu;
        drv(1'b1, 2'b10, 1'b0, 1'b0, 64'h1234, 5'd5, 1'b1);
        #1;
        nt++;
        if (stall !== 1'b0) begin
            nf++; $display("FAIL alu_stall: got %b want 0", stall);
        end
        sb.push_back(exp_t'{res: 64'h1234, rd: 5'd5, rw: 1'b1});
        tick;
        nt++;
        if ({o_rv, o_rw, o_rd, o_res} !== {1'b1, 1'b1, 5'd5, 64'h1234}) begin
            nf++;
            $display("FAIL alu_direct: got rv=%b rw=%b rd=%0d res=%h want 1 1 5 1234",
                     o_rv, o_rw, o_rd, o_res);
        end
        drv(1'b1, 2'b11, 1'b0, 1'b1, 64'h55AA, 5'd6, 1'b1);
        #1;
        nt++;
        if (stall !== 1'b0) begin
            nf++; $display("FAIL alu11_stall: got %b want 0", stall);
        end
        sb.push_back(exp_t'{res: 64'h55AA, rd: 5'd6, rw: 1'b1});
        tick;
        drv(1'b1, 2'b10, 1'b0, 1'b0, 64'h77, 5'd8, 1'b0);
        sb.push_back(exp_t'{res: 64'h77, rd: 5'd8, rw: 1'b0});
        tick;
        drv(1'b0, 2'b00, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1);
        repeat (2) tick;
        nt++;
        if (sb.size() != 0) begin
            nf++; $display("FAIL alu_drain: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_mul;
        for (int c = 0; c <= 4; c++) begin
            drv(1'b1, 2'b00, 1'b0, c == 4, (c == 4) ? 64'hDEAD : 64'hFFFF_0000,
                5'd7, 1'b1);
            #1;
            nt++;
            if (stall !== (c < 4)) begin
                nf++; $display("FAIL mul_stall c=%0d: got %b want %b", c, stall, c < 4);
            end
            if (c == 4) begin
                nt++;
                if (bcnt !== 7'd3) begin
                    nf++; $display("FAIL mul_busycnt: got %0d want 3", bcnt);
                end
                sb.push_back(exp_t'{res: 64'hDEAD, rd: 5'd7, rw: 1'b1});
            end
            tick;
        end
        drv(1'b0, 2'b00, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0);
        repeat (2) tick;
        nt++;
        if (sb.size() != 0) begin
            nf++; $display("FAIL mul_drain: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_flush_drain;
        logic [8:0] es;
        es = 9'b010111011;
        for (int c = 0; c <= 8; c++) begin
            case (c)
                0, 1: drv(1'b1, 2'b01, 1'b0, 1'b0, 64'h0, 5'd9, 1'b1);
                2: drv(1'b1, 2'b01, 1'b1, 1'b0, 64'h0, 5'd9, 1'b1);
                3, 4, 5: drv(1'b0, 2'b00, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0);
                6: drv(1'b0, 2'b00, 1'b0, 1'b1, 64'hBAD, 5'd9, 1'b1);
                7: drv(1'b1, 2'b00, 1'b0, 1'b0, 64'h0, 5'd10, 1'b1);
                default: drv(1'b1, 2'b00, 1'b0, 1'b1, 64'h600D, 5'd10, 1'b1);
            endcase
            #1;
            nt++;
            if (stall !== es[c]) begin
                nf++; $display("FAIL drain_stall c=%0d: got %b want %b", c, stall, es[c]);
            end
            if (c == 3) begin
                nt++;
                if (bcnt !== 7'd0) begin
                    nf++; $display("FAIL drain_busycnt: got %0d want 0", bcnt);
                end
            end
            if (c == 8) sb.push_back(exp_t'{res: 64'h600D, rd: 5'd10, rw: 1'b1});
            tick;
        end
        drv(1'b0, 2'b00, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0);
        repeat (2) tick;
        nt++;
        if (sb.size() != 0) begin
            nf++; $display("FAIL drain_pending: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_timeout;
        for (int c = 0; c <= 8; c++) begin
            drv(1'b1, 2'b01, 1'b0, 1'b0, 64'hCAFE, 5'd11, 1'b1);
            #1;
            nt++;
            if (stall !== (c < 8)) begin
                nf++; $display("FAIL to_stall c=%0d: got %b want %b", c, stall, c < 8);
            end
            if (c == 8) begin
                nt++;
                if ({bcnt, o_to} !== {7'd7, 1'b0}) begin
                    nf++; $display("FAIL to_pre: got cnt=%0d to=%b want 7 0", bcnt, o_to);
                end
            end
            tick;
        end
        drv(1'b0, 2'b00, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0);
        #1;
        nt++;
        if ({o_to, o_rw, o_rv, bcnt} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin
            nf++;
            $display("FAIL to_abort: got to=%b rw=%b rv=%b cnt=%0d want 1 0 0 0",
                     o_to, o_rw, o_rv, bcnt);
        end
        repeat (3) tick;
        nt++;
        if (o_to !== 1'b1) begin
            nf++; $display("FAIL to_sticky: got %b want 1", o_to);
        end
    endtask

    task automatic test_reset_mid;
        drv(1'b1, 2'b10, 1'b0, 1'b0, 64'hABC, 5'd12, 1'b1);
        sb.push_back(exp_t'{res: 64'hABC, rd: 5'd12, rw: 1'b1});
        tick;
        for (int c = 0; c <= 4; c++) begin
            drv(1'b1, 2'b00, 1'b0, 1'b0, 64'h0, 5'd13, 1'b1);
            #1;
            if (c == 4) begin
                nt++;
                if (bcnt !== 7'd3) begin
                    nf++; $display("FAIL rstmid_busycnt: got %0d want 3", bcnt);
                end
                rst = 1'b0;
            end
            tick;
        end
        rst = 1'b1;
        drv(1'b0, 2'b00, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0);
        #1;
        nt++;
        if ({bcnt, stall, o_to} !== {7'd0, 1'b0, 1'b0}) begin
            nf++;
            $display("FAIL rstmid_ctl: got cnt=%0d stall=%b to=%b want 0 0 0",
                     bcnt, stall, o_to);
        end
        nt++;
        if ({o_res, o_rd, o_rw, o_rv} !== 71'd0) begin
            nf++;
            $display("FAIL rstmid_out: got res=%h rd=%0d rw=%b rv=%b want all 0",
                     o_res, o_rd, o_rw, o_rv);
        end
        drv(1'b1, 2'b01, 1'b0, 1'b1, 64'h7777, 5'd14, 1'b1);
        #1;
        nt++;
        if (stall !== 1'b0) begin
            nf++; $display("FAIL immed_stall: got %b want 0", stall);
        end
        sb.push_back(exp_t'{res: 64'h7777, rd: 5'd14, rw: 1'b1});
        tick;
        drv(1'b0, 2'b00, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0);
        repeat (2) tick;
        nt++;
        if (sb.size() != 0) begin
            nf++; $display("FAIL rstmid_pending: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] es;
        es = 9'b011111011;
        for (int c = 0; c <= 8; c++) begin
            if (c <= 2)
                drv(1'b1, 2'b00, 1'b0, c == 2, 64'h1111, 5'd3, 1'b1);
            else
                drv(1'b1, 2'b01, 1'b0, c == 8, 64'h2222, 5'd4, 1'b1);
            #1;
            nt++;
            if (stall !== es[c]) begin
                nf++; $display("FAIL b2b_stall c=%0d: got %b want %b", c, stall, es[c]);
            end
            if (c == 2) sb.push_back(exp_t'{res: 64'h1111, rd: 5'd3, rw: 1'b1});
            if (c == 8) sb.push_back(exp_t'{res: 64'h2222, rd: 5'd4, rw: 1'b1});
            tick;
        end
        drv(1'b0, 2'b00, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0);
        repeat (3) tick;
        nt++;
        if (sb.size() != 0) begin
            nf++; $display("FAIL b2b_pending: got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_mul;
        test_flush_drain;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule

// File: doc/riscv_icu_seq.md
# riscv_icu_seq

Execute-stage sequencer and EX/MEM result register sitting directly downstream of the integer compute unit (ALU/branch/multiplier/divider). It detects issue of multi-cycle mul/div operations and holds the upstream pipeline with a stall until the unit reports `valid`. It registers the selected result with its destination tag toward the memory stage. It also drains results orphaned by a flush and flags hung operations with a timeout.

## Interface
- `TIMEOUT`, 96: cycles in WAIT/DRAIN before abort; legal range 2..127.
- `i_riscv_icuseq_clk`  in  1  clock; all state changes on rising edge.
- `i_riscv_icuseq_rst`  in  1  reset; synchronous, active-low.
- `i_riscv_icuseq_instvalid`  in  1  EX stage holds a valid instruction.
- `i_riscv_icuseq_funcsel`  in  2  00 mul, 01 div, 10 alu, 11 treated as alu.
- `i_riscv_icuseq_flush`  in  1  kill the EX instruction this cycle.
- `i_riscv_icuseq_icuvalid`  in  1  mul/div result ready (compute-unit valid).
- `i_riscv_icuseq_icuresult`  in  64  compute-unit result.
- `i_riscv_icuseq_rdaddr`  in  5  destination register of EX instruction.
- `i_riscv_icuseq_regwrite`  in  1  EX instruction writes rd.
- `o_riscv_icuseq_stall`  out  1  combinational; hold IF/ID/EX.
- `o_riscv_icuseq_result`  out  64  registered result to MEM.
- `o_riscv_icuseq_rdaddr`  out  5  registered rd.
- `o_riscv_icuseq_regwrite`  out  1  registered write enable.
- `o_riscv_icuseq_resvalid`  out  1  registered; MEM slot holds a live instruction.
- `o_riscv_icuseq_timeout`  out  1  sticky abort flag.
- `o_riscv_icuseq_busycnt`  out  7  cycles spent in current WAIT/DRAIN.

## Operation
- Definitions: `md = instvalid & ~funcsel[1]`.
- States: IDLE, WAIT, DRAIN.
- IDLE:
  - If `md & ~flush & ~icuvalid`, go to WAIT with stall=1.
  - If `md & ~flush & icuvalid`, complete immediately with stall=0.
  - Otherwise (ALU, bubble, or flush), stall=0.
  - A stray icuvalid with no md issue is ignored.
- WAIT:
  - stall = `~icuvalid & ~flush`.
  - icuvalid (no flush): go to IDLE; the output register captures the result.
  - flush without icuvalid: go to DRAIN.
  - flush with icuvalid: go to IDLE; the output register loads a bubble.
- DRAIN:
  - stall=1 in every DRAIN cycle.
  - icuvalid: result discarded, go to IDLE; stall=0 that cycle.
  - Exists because the mul/div cannot abort; it prevents a stale valid from completing the next op.
- Timeout:
  - busycnt clears on entry to WAIT or DRAIN, increments each cycle there, and is 0 in IDLE.
  - If busycnt == TIMEOUT-1 with no icuvalid, go to IDLE, deassert stall, and set timeout=1 (sticky until reset).
  - In that abort cycle the output register loads a bubble.
- Output register, every edge:
  - If stall=1 or flush=1: load a bubble (regwrite=0, resvalid=0; result and rdaddr hold their values).
  - Otherwise: result←icuresult, rdaddr←rdaddr, regwrite←regwrite&instvalid, resvalid←instvalid.
  - Exception: a WAIT timeout abort or a DRAIN exit loads a bubble even with stall=0.

## Timing
- Reset (rst=0 at an edge): state=IDLE, busycnt=0, and all registered outputs are 0 (including timeout). stall=0 while in IDLE with no md.
- Reset overrides everything, including mid-WAIT/DRAIN; the first cycle after release is IDLE.
- ALU op: result appears on outputs 1 cycle after the EX cycle; no stall.
- Mul/div issued at cycle T with icuvalid at T+k (k≥1):
  - stall is high for cycles T..T+k-1 and low at T+k.
  - Outputs show the result at T+k+1.
  - busycnt=k-1 at cycle T+k.
- Back-to-back md ops: the second issues in the cycle after the first completes; there is no idle cycle.
- Stall depends only on the current state and current inputs; there is no path from outputs to stall.

## Test plan
- Reset, then ALU op (rd=5, result=0x1234) → next cycle regwrite=1, rdaddr=5, result=0x1234, resvalid=1, stall never asserted.
- Mul issued at T, icuvalid at T+4 with result=0xDEAD → stall high T..T+3 and low at T+4; outputs show 0xDEAD, regwrite=1, at T+5.
- Div issued, flush at T+2, icuvalid at T+6 with result=0xBAD → state DRAIN, stall high through T+5, 0xBAD never appears with resvalid=1; a following mul completes normally with its own result.
- Div issued, icuvalid never arrives, TIMEOUT=8 → stall drops at T+8, timeout=1 and stays 1, and a bubble is written (regwrite=0).
- rst=0 asserted during WAIT at busycnt=3 → next cycle state IDLE, busycnt=0, stall=0, all outputs 0.
- Mul (icuvalid after 2 cycles) immediately followed by div (after 5) → stall pattern 1,1,0,1,1,1,1,1,0; two results delivered in order, each with resvalid=1 for exactly one cycle.
